ddr_lane_dly_seq: RTL and testbench

- Fabric-side sequencer that drives the IOD delay-line controls (MOVE/DIRECTION/LOAD) for NUM_LANES DDR4 lanes (DQ/DM/DQS) from one command port.
- Tracks the current tap of every lane, expands multi-tap and absolute-set requests into spaced single-tap pulses, and aborts on the per-lane out-of-range flag.
- Sits between training/calibration logic and the per-lane IOD wrappers.

---
 rtl/ddr_dly_seq_pkg.sv | 25 ++
 rtl/ddr_lane_dly_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_ddr_lane_dly_seq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ddr_dly_seq_pkg.sv
// rtl/ddr_dly_seq_pkg.sv - shared encodings and defaults for the DDR lane delay sequencer
package ddr_dly_seq_pkg;

  localparam int DEF_NUM_LANES = 9;
  localparam int DEF_TAP_W     = 8;
  localparam int DEF_LOAD_VAL  = 1;
  localparam int DEF_MOVE_GAP  = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_SET  = 2'b11
  } dly_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_MOVE  = 3'd3,
    ST_GAP   = 3'd4,
    ST_FIN   = 3'd5
  } dly_state_e;

endpackage

// File: rtl/ddr_lane_dly_seq.sv
// rtl/ddr_lane_dly_seq.sv - IOD delay-line MOVE/DIRECTION/LOAD sequencer with per-lane tap tracking
// Optional macro DLY_SEQ_BOUND_CHECK_EN: reject out-of-range INC/DEC in SETUP before any pulse.
module ddr_lane_dly_seq
  import ddr_dly_seq_pkg::*;
#(
  parameter int  NUM_LANES = DEF_NUM_LANES,
  parameter int  TAP_W     = DEF_TAP_W,
  parameter int  LOAD_VAL  = DEF_LOAD_VAL,
  parameter int  MOVE_GAP  = DEF_MOVE_GAP,
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                       FAB_CLK,
  input  logic                       ARST_N,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [LANE_W-1:0]          cmd_lane,
  input  logic [1:0]                 cmd_op,
  input  logic [TAP_W-1:0]           cmd_arg,
  output logic                       done,
  output logic                       err,
  output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
  input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_LANES*TAP_W-1:0] tap_val
);

  localparam int GAP_W = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;

  dly_state_e           state_q, state_d;
  dly_op_e              op_q, op_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [TAP_W-1:0]     arg_q, arg_d;
  logic [TAP_W-1:0]     rem_q, rem_d;
  logic                 dir_q, dir_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 err_q, err_d;
  logic [NUM_LANES-1:0] dir_lines_q, dir_lines_d;

  logic [NUM_LANES-1:0] lane_sel;
  logic [TAP_W-1:0]     cur_tap;
  logic                 lane_bad;
  logic                 oor_hit;
  logic                 setup_dir;
  logic [TAP_W-1:0]     setup_rem;
  logic                 bound_viol;
  logic                 tap_up, tap_dn, tap_ld;

  // One-hot decode of the registered target lane; an out-of-range lane selects nothing.
  always_comb begin
    lane_sel = '0;
    cur_tap  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_q == LANE_W'(i)) begin
        lane_sel[i] = 1'b1;
        cur_tap     = tap_val[i*TAP_W +: TAP_W];
      end
    end
  end

  assign lane_bad = ({1'b0, cmd_lane} >= (LANE_W+1)'(NUM_LANES));
  assign oor_hit  = |(DELAY_LINE_OUT_OF_RANGE & lane_sel);

  always_comb begin
    setup_dir = |(dir_lines_q & lane_sel);
    setup_rem = '0;
    case (op_q)
      OP_INC: begin
        setup_dir = 1'b1;
        setup_rem = arg_q;
      end
      OP_DEC: begin
        setup_dir = 1'b0;
        setup_rem = arg_q;
      end
      OP_SET: begin
        setup_dir = (arg_q > cur_tap);
        setup_rem = (arg_q > cur_tap) ? (arg_q - cur_tap) : (cur_tap - arg_q);
      end
      default: ;
    endcase
  end

`ifdef DLY_SEQ_BOUND_CHECK_EN
  assign bound_viol = ((op_q == OP_INC) &&
                       (({1'b0, cur_tap} + {1'b0, arg_q}) > {1'b0, {TAP_W{1'b1}}})) ||
                      ((op_q == OP_DEC) && (arg_q > cur_tap));
`else
  assign bound_viol = 1'b0;
`endif

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LOAD;
      lane_q      <= '0;
      arg_q       <= '0;
      rem_q       <= '0;
      dir_q       <= 1'b0;
      gap_q       <= '0;
      err_q       <= 1'b0;
      dir_lines_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      arg_q       <= arg_d;
      rem_q       <= rem_d;
      dir_q       <= dir_d;
      gap_q       <= gap_d;
      err_q       <= err_d;
      dir_lines_q <= dir_lines_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    lane_d      = lane_q;
    arg_d       = arg_q;
    rem_d       = rem_q;
    dir_d       = dir_q;
    gap_d       = gap_q;
    err_d       = err_q;
    dir_lines_d = dir_lines_q;
    tap_up      = 1'b0;
    tap_dn      = 1'b0;
    tap_ld      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          lane_d  = cmd_lane;
          op_d    = dly_op_e'(cmd_op);
          arg_d   = cmd_arg;
          err_d   = lane_bad;
          state_d = lane_bad ? ST_FIN : ST_SETUP;
        end
      end
      ST_SETUP: begin
        dir_d       = setup_dir;
        rem_d       = setup_rem;
        dir_lines_d = (dir_lines_q & ~lane_sel) | ({NUM_LANES{setup_dir}} & lane_sel);
        if (op_q == OP_LOAD) begin
          state_d = ST_LOAD;
        end else if (bound_viol) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (setup_rem == '0) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_MOVE;
        end
      end
      ST_LOAD: begin
        tap_ld  = 1'b1;
        state_d = ST_FIN;
      end
      ST_MOVE: begin
        tap_up  = dir_q;
        tap_dn  = !dir_q;
        rem_d   = rem_q - TAP_W'(1);
        gap_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        // The IOD refused the last step, so the tracked tap steps back to match it.
        if (oor_hit) begin
          tap_up  = !dir_q;
          tap_dn  = dir_q;
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if (gap_q == GAP_W'(MOVE_GAP - 1)) begin
          state_d = (rem_q == '0) ? ST_FIN : ST_MOVE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    cmd_ready            = (state_q == ST_IDLE);
    done                 = (state_q == ST_FIN);
    err                  = err_q;
    DELAY_LINE_MOVE      = (state_q == ST_MOVE) ? lane_sel : '0;
    DELAY_LINE_LOAD      = (state_q == ST_LOAD) ? lane_sel : '0;
    DELAY_LINE_DIRECTION = dir_lines_q;
    if (state_q == ST_SETUP) begin
      DELAY_LINE_DIRECTION = (dir_lines_q & ~lane_sel) | ({NUM_LANES{setup_dir}} & lane_sel);
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [TAP_W-1:0] tap_q, tap_d;

    always_comb begin
      tap_d = tap_q;
      if (lane_sel[g]) begin
        if (tap_ld) begin
          tap_d = TAP_W'(LOAD_VAL);
        end else if (tap_up) begin
          tap_d = tap_q + TAP_W'(1);
        end else if (tap_dn) begin
          tap_d = tap_q - TAP_W'(1);
        end
      end
    end

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
        tap_q <= TAP_W'(LOAD_VAL);
      end else begin
        tap_q <= tap_d;
      end
    end

    assign tap_val[g*TAP_W +: TAP_W] = tap_q;
  end

endmodule

// File: tb/tb_ddr_lane_dly_seq.sv
// tb/tb_ddr_lane_dly_seq.sv - directed table-driven bench for ddr_lane_dly_seq
module tb_ddr_lane_dly_seq;
  import ddr_dly_seq_pkg::*;

  localparam int NL = 9;
  localparam int TW = 8;
  localparam int LW = 4;

  logic              FAB_CLK = 1'b0;
  logic              ARST_N  = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [LW-1:0]     cmd_lane = '0;
  logic [1:0]        cmd_op = '0;
  logic [TW-1:0]     cmd_arg = '0;
  logic              done;
  logic              err;
  logic [NL-1:0]     mv, dirl, ld;
  logic [NL-1:0]     oor = '0;
  logic [NL*TW-1:0]  tap_val;

  int n_tests = 0;
  int n_fail  = 0;

  ddr_lane_dly_seq dut (
    .FAB_CLK                 (FAB_CLK),
    .ARST_N                  (ARST_N),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_lane                (cmd_lane),
    .cmd_op                  (cmd_op),
    .cmd_arg                 (cmd_arg),
    .done                    (done),
    .err                     (err),
    .DELAY_LINE_MOVE         (mv),
    .DELAY_LINE_DIRECTION    (dirl),
    .DELAY_LINE_LOAD         (ld),
    .DELAY_LINE_OUT_OF_RANGE (oor),
    .tap_val                 (tap_val)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct {
    int      lane;
    dly_op_e op;
    int      arg;
    int      oor_after;
    int      cyc;
    int      moves;
    int      loads;
    logic    dir;
    int      tap;
    logic    err;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input int lane, input dly_op_e op, input int arg, input int oor_after,
                              input int cyc, input int moves, input int loads, input logic dir,
                              input int tap, input logic e);
    vec_t v;
    v.lane = lane; v.op = op; v.arg = arg; v.oor_after = oor_after;
    v.cyc = cyc; v.moves = moves; v.loads = loads; v.dir = dir; v.tap = tap; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int tap_of(input int lane);
    logic [NL*TW-1:0] t;
    t = tap_val;
    return int'(t[lane*TW +: TW]);
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the IDLE cycle after FIN.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc, done_cyc, moves, loads, stray, dir_bad, ready_hi;
    logic [NL-1:0] tmask, dir_snap;
    tmask    = NL'(1) << v.lane;
    dir_snap = dirl & ~tmask;
    chk($sformatf("v%0d_ready_before", idx), cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_lane  = LW'(v.lane);
    cmd_op    = v.op;
    cmd_arg   = TW'(v.arg);
    cyc = 0; done_cyc = 0; moves = 0; loads = 0; stray = 0; dir_bad = 0; ready_hi = 0;
    while (done_cyc == 0 && cyc < 300) begin
      @(negedge FAB_CLK);
      cyc++;
      if (cyc == 1) cmd_valid = 1'b0;
      if ((mv & tmask) != '0) begin
        moves++;
        if ((dirl & tmask) != (v.dir ? tmask : '0)) dir_bad++;
      end
      if ((ld & tmask) != '0) loads++;
      if (((mv | ld) & ~tmask) != '0) stray++;
      if ((dirl & ~tmask) != dir_snap) stray++;
      if (cmd_ready) ready_hi++;
      if (v.oor_after > 0 && moves == v.oor_after) oor = tmask;
      if (done) done_cyc = cyc;
    end
    oor = '0;
    @(negedge FAB_CLK);
    chk($sformatf("v%0d_done_cycle", idx), done_cyc, v.cyc);
    chk($sformatf("v%0d_moves", idx), moves, v.moves);
    chk($sformatf("v%0d_loads", idx), loads, v.loads);
    chk($sformatf("v%0d_stray", idx), stray, 0);
    chk($sformatf("v%0d_dir_bad", idx), dir_bad, 0);
    chk($sformatf("v%0d_ready_busy", idx), ready_hi, 0);
    chk($sformatf("v%0d_err", idx), err, v.err);
    chk($sformatf("v%0d_done_single", idx), done, 0);
    if (v.lane < NL) chk($sformatf("v%0d_tap", idx), tap_of(v.lane), v.tap);
  endtask

  initial begin
    int c, first_done, second_done, ready_early, ready_c4, loads4, moves4, mcount;

    #1000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c, first_done, second_done, ready_early, ready_c4, loads4, moves4, mcount;

    vecs[0]  = mk(3,  OP_LOAD, 0,  0, 3,  0, 1, 1'b0, 1, 1'b0);
    vecs[1]  = mk(0,  OP_INC,  5,  0, 27, 5, 0, 1'b1, 6, 1'b0);
    vecs[2]  = mk(2,  OP_INC,  2,  0, 12, 2, 0, 1'b1, 3, 1'b0);
    vecs[3]  = mk(2,  OP_SET,  0,  0, 17, 3, 0, 1'b0, 0, 1'b0);
    vecs[4]  = mk(2,  OP_SET,  0,  0, 2,  0, 0, 1'b0, 0, 1'b0);
    vecs[5]  = mk(1,  OP_INC,  10, 4, 19, 4, 0, 1'b1, 4, 1'b1);
    vecs[6]  = mk(1,  OP_SET,  6,  0, 12, 2, 0, 1'b1, 6, 1'b0);
    vecs[7]  = mk(12, OP_INC,  3,  0, 1,  0, 0, 1'b1, 0, 1'b1);
    vecs[8]  = mk(0,  OP_DEC,  2,  0, 12, 2, 0, 1'b0, 4, 1'b0);
    vecs[9]  = mk(0,  OP_LOAD, 0,  0, 3,  0, 1, 1'b0, 1, 1'b0);
`ifdef DLY_SEQ_BOUND_CHECK_EN
    vecs[10] = mk(0,  OP_DEC,  2,  1, 2,  0, 0, 1'b0, 1, 1'b1);
`else
    vecs[10] = mk(0,  OP_DEC,  2,  1, 4,  1, 0, 1'b0, 1, 1'b1);
`endif
    vecs[11] = mk(8,  OP_INC,  1,  0, 7,  1, 0, 1'b1, 2, 1'b0);

    repeat (3) @(negedge FAB_CLK);
    ARST_N = 1'b1;
    @(negedge FAB_CLK);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_move", mv, 0);
    chk("rst_load", ld, 0);
    chk("rst_dir", dirl, 0);
    for (int i = 0; i < NL; i++) chk($sformatf("rst_tap%0d", i), tap_of(i), 1);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // cmd_valid held high across a LOAD; the follow-on INC is taken the cycle after done.
    cmd_valid = 1'b1; cmd_lane = 4'd4; cmd_op = OP_LOAD; cmd_arg = 8'd0;
    first_done = 0; second_done = 0; ready_early = 0; ready_c4 = 0; loads4 = 0; moves4 = 0;
    for (c = 1; c <= 14; c++) begin
      @(negedge FAB_CLK);
      if (c == 1) begin
        cmd_op = OP_INC; cmd_arg = 8'd1;
      end
      if (c == 5) cmd_valid = 1'b0;
      if (c <= 3 && cmd_ready) ready_early++;
      if (c == 4) ready_c4 = int'(cmd_ready);
      if (ld[4]) loads4++;
      if (mv[4]) moves4++;
      if (done && first_done == 0) first_done = c;
      else if (done) second_done = c;
    end
    chk("b2b_first_done", first_done, 3);
    chk("b2b_second_done", second_done, 11);
    chk("b2b_ready_busy", ready_early, 0);
    chk("b2b_ready_c4", ready_c4, 1);
    chk("b2b_loads", loads4, 1);
    chk("b2b_moves", moves4, 1);
    chk("b2b_tap4", tap_of(4), 2);

    // Reset mid-operation, right after the second MOVE on lane 7.
    cmd_valid = 1'b1; cmd_lane = 4'd7; cmd_op = OP_INC; cmd_arg = 8'd3;
    mcount = 0;
    for (c = 1; c <= 40 && mcount < 2; c++) begin
      @(negedge FAB_CLK);
      if (c == 1) cmd_valid = 1'b0;
      if (mv[7]) mcount++;
    end
    chk("arst_reached_move", mcount, 2);
    chk("arst_move_before", mv[7], 1);
    #2 ARST_N = 1'b0;
    #1;
    chk("arst_move", mv, 0);
    chk("arst_tap7", tap_of(7), 1);
    chk("arst_tap2", tap_of(2), 1);
    chk("arst_dir", dirl, 0);
    chk("arst_ready", cmd_ready, 1);
    @(negedge FAB_CLK);
    ARST_N = 1'b1;
    @(negedge FAB_CLK);
    chk("arst_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
